vga_fb_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM between the VGA scan-out reader and a pixel-draw writer, and adds a hardware clear engine. Sits between `vga_controller` (supplies `video_on`, `curr_x`, `curr_y`, sync) and the framebuffer RAM, all on the 25 MHz pixel clock. It emits the final `rgb` and matching delayed `hsync`/`vsync` to the pins. Each framebuffer pixel is scaled 4x4 to the 640x480 screen.

---
 rtl/vga_fb_arbiter.sv | 145 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port arbiter: VGA scan-out reads take every phase-0 active
// pixel, remaining cycles serve the pixel writer or the hardware clear engine.
module vga_fb_arbiter #(
   parameter int FB_W   = 160,
   parameter int FB_H   = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              video_on,
   input  logic [9:0]        curr_x,
   input  logic [9:0]        curr_y,
   input  logic              hsync_in,
   input  logic              vsync_in,
   output logic              hsync,
   output logic              vsync,
   output logic [11:0]       rgb,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [11:0]       wr_data,
   input  logic              clear_start,
   input  logic [11:0]       clear_color,
   output logic              busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [11:0]       ram_wdata,
   input  logic [11:0]       ram_rdata
);
   localparam logic [31:0]       FB_SIZE   = 32'(FB_W * FB_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
   logic [11:0]       clr_color;
   logic              done_nxt, done_r;
   logic              rd_slot;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_in_range;

   logic              rd_p1;
   logic              vid_p1, vid_p2;
   logic              hs_p1, hs_p2;
   logic              vs_p1, vs_p2;
   logic [11:0]       pix_p2;

   // Stage 0: arbitration and RAM address/write generation
   assign rd_slot     = video_on && (curr_x[1:0] == 2'd0);
   assign rd_addr     = ADDR_W'(32'(curr_y >> 2) * 32'(FB_W) + 32'(curr_x >> 2));
   assign wr_in_range = 32'(wr_addr) < FB_SIZE;

   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      done_nxt     = 1'b0;
      wr_ready     = 1'b0;
      busy         = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = rd_addr;
      ram_wdata    = wr_data;
      case (state)
         IDLE: begin
            wr_ready = !rd_slot;
            if (!rd_slot) begin
               ram_addr = wr_addr;
               ram_we   = wr_valid && wr_in_range;
            end
            if (clear_start) begin
               state_nxt    = CLEAR;
               clr_addr_nxt = '0;
            end
         end
         CLEAR: begin
            busy = 1'b1;
            if (!rd_slot) begin
               ram_addr     = clr_addr;
               ram_we       = 1'b1;
               ram_wdata    = clr_color;
               clr_addr_nxt = clr_addr + 1'b1;
               if (clr_addr == LAST_ADDR) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Nothing may be accepted or written while reset is held.
      if (reset) begin
         wr_ready = 1'b0;
         ram_we   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         clr_addr <= '0;
         done_r   <= 1'b0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         done_r   <= done_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && clear_start)
         clr_color <= clear_color;
   end

   assign clear_done = done_r;

   // Stage 1/2: RAM read return, pixel hold and sync/video alignment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_p1  <= 1'b0;
         vid_p1 <= 1'b0;
         vid_p2 <= 1'b0;
         hs_p1  <= 1'b0;
         hs_p2  <= 1'b0;
         vs_p1  <= 1'b0;
         vs_p2  <= 1'b0;
         pix_p2 <= 12'h000;
      end else begin
         rd_p1  <= rd_slot;
         vid_p1 <= video_on;
         vid_p2 <= vid_p1;
         hs_p1  <= hsync_in;
         hs_p2  <= hs_p1;
         vs_p1  <= vsync_in;
         vs_p2  <= vs_p1;
         if (rd_p1)
            pix_p2 <= ram_rdata;
      end
   end

   assign rgb   = vid_p2 ? pix_p2 : 12'h000;
   assign hsync = hs_p2;
   assign vsync = vs_p2;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural framebuffer RAM,
// a scan-out scoreboard and a clear-engine write monitor.
module tb_vga_fb_arbiter;
   localparam int FB_SZ = 19200;

   logic        clk, reset;
   logic        video_on;
   logic [9:0]  curr_x, curr_y;
   logic        hsync_in, vsync_in, hsync, vsync;
   logic [11:0] rgb;
   logic        wr_valid, wr_ready;
   logic [14:0] wr_addr;
   logic [11:0] wr_data;
   logic        clear_start;
   logic [11:0] clear_color;
   logic        busy, clear_done;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [11:0] ram_wdata, ram_rdata;

   vga_fb_arbiter dut (
      .clk(clk), .reset(reset), .video_on(video_on), .curr_x(curr_x), .curr_y(curr_y),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .clear_start(clear_start), .clear_color(clear_color), .busy(busy),
      .clear_done(clear_done), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] fb_mem [0:32767];
   always @(posedge clk) begin
      if (ram_we) fb_mem[ram_addr] <= ram_wdata;
      ram_rdata <= fb_mem[ram_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference picture: only the pixels the bench has written itself
   logic [11:0] ref_mem [0:FB_SZ-1];

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;
   exp_t q[$];
   logic sb_en;

   always @(negedge clk) begin
      exp_t e, o;
      if (!sb_en) q.delete();
      else begin
         e.rgb = video_on ? ref_mem[(int'(curr_y) / 4) * 160 + int'(curr_x) / 4] : 12'h000;
         e.hs  = hsync_in;
         e.vs  = vsync_in;
         q.push_back(e);
         if (q.size() == 3) begin
            o = q.pop_front();
            chk("sb_rgb", rgb, o.rgb);
            chk("sb_hsync", hsync, o.hs);
            chk("sb_vsync", vsync, o.vs);
         end
      end
   end

   // Clear-engine monitor
   logic        mon_clr;
   logic [11:0] exp_clr;
   int we_cnt, busy_cnt, done_cnt, bad_data, ph0_we;
   int wcnt [0:FB_SZ-1];

   always @(posedge clk) begin
      if (mon_clr) begin
         we_cnt <= 0; busy_cnt <= 0; done_cnt <= 0; bad_data <= 0; ph0_we <= 0;
         for (int i = 0; i < FB_SZ; i++) wcnt[i] <= 0;
      end else begin
         if (busy) busy_cnt <= busy_cnt + 1;
         if (clear_done) done_cnt <= done_cnt + 1;
         if (ram_we && busy) begin
            we_cnt <= we_cnt + 1;
            if (int'(ram_addr) < FB_SZ) wcnt[ram_addr] <= wcnt[ram_addr] + 1;
            if (ram_wdata != exp_clr) bad_data <= bad_data + 1;
         end
         if (ram_we && video_on && curr_x[1:0] == 2'd0) ph0_we <= ph0_we + 1;
      end
   end

   int sx, sy;

   task automatic wr_px(input int a, input logic [11:0] d);
      int n = 0;
      wr_valid = 1'b1; wr_addr = 15'(a); wr_data = d;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
         step(); @(negedge clk); n++;
      end
      chk("wr_ready", wr_ready, 1);
      chk("wr_we", ram_we, (a < FB_SZ) ? 1 : 0);
      chk("wr_addr", ram_addr, a);
      step();
      wr_valid = 1'b0;
      if (a < FB_SZ) ref_mem[a] = d;
   endtask

   task automatic scan_line(input int y, input int nx);
      video_on = 1'b0; curr_y = 10'(y); curr_x = 10'd0; sb_en = 1'b1;
      step(); step();
      for (int x = 0; x < nx; x++) begin
         video_on = 1'b1; curr_x = 10'(x);
         hsync_in = 1'($urandom_range(0, 1));
         vsync_in = 1'($urandom_range(0, 1));
         step();
      end
      video_on = 1'b0;
      repeat (4) step();
      sb_en = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input bit scan);
      int n = 0;
      bit seen = 0;
      while (n < budget && !seen) begin
         if (scan) begin video_on = 1'b1; curr_x = 10'(sx); curr_y = 10'(sy); end
         clear_start = (n == 100);
         clear_color = 12'hF0F;
         @(negedge clk);
         if (n == 50) chk("clr_no_ready", wr_ready, 0);
         if (clear_done) begin
            seen = 1;
            chk("done_busy", busy, 0);
            chk("done_ready", wr_ready, (video_on && curr_x[1:0] == 2'd0) ? 0 : 1);
         end
         step();
         n++;
         if (scan) begin
            sx++;
            if (sx == 640) begin sx = 0; sy = (sy + 1) % 480; end
         end
      end
      clear_start = 1'b0;
      chk("clr_timeout", seen, 1);
   endtask

   task automatic clr_checks();
      int badc = 0;
      for (int i = 0; i < FB_SZ; i++) if (wcnt[i] != 1) badc++;
      chk("clr_writes", we_cnt, FB_SZ);
      chk("clr_cover", badc, 0);
      chk("clr_data", bad_data, 0);
      chk("clr_done_cnt", done_cnt, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; video_on = 1'b0; curr_x = '0; curr_y = '0;
      hsync_in = 1'b1; vsync_in = 1'b1;
      wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 12'hABC;
      clear_start = 1'b0; clear_color = '0;
      sb_en = 1'b0; mon_clr = 1'b1; exp_clr = '0; sx = 0; sy = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      step();
      reset = 1'b0; wr_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; mon_clr = 1'b0;
      step();

      // Reader priority over a pending write
      video_on = 1'b1; curr_x = 10'd8; curr_y = 10'd4;
      wr_valid = 1'b1; wr_addr = 15'd300; wr_data = 12'h123;
      @(negedge clk);
      chk("rp_ready", wr_ready, 0);
      chk("rp_addr", ram_addr, 162);
      chk("rp_we", ram_we, 0);
      step();
      curr_x = 10'd9;
      @(negedge clk);
      chk("rp_ready1", wr_ready, 1);
      chk("rp_we1", ram_we, 1);
      chk("rp_addr1", ram_addr, 300);
      chk("rp_wdata1", ram_wdata, 12'h123);
      step();
      wr_valid = 1'b0; video_on = 1'b0;
      ref_mem[300] = 12'h123;

      wr_px(0, 12'hF00);   wr_px(1, 12'h0F0);   wr_px(2, 12'h00F);   wr_px(3, 12'hFFF);
      wr_px(160, 12'h111); wr_px(161, 12'hABC); wr_px(162, 12'h5A5);

      scan_line(0, 16);
      scan_line(4, 12);

      wr_px(FB_SZ, 12'h777);

      // Clear during blanking, with a write handshake on the start cycle
      exp_clr = 12'h00F; mon_clr = 1'b1; step(); mon_clr = 1'b0;
      video_on = 1'b0; wr_valid = 1'b1; wr_addr = 15'd50; wr_data = 12'h555;
      clear_start = 1'b1; clear_color = 12'h00F;
      @(negedge clk);
      chk("cs_wr_we", ram_we, 1);
      chk("cs_wr_addr", ram_addr, 50);
      chk("cs_busy", busy, 0);
      step();
      clear_start = 1'b0;
      @(negedge clk);
      chk("cl_busy", busy, 1);
      chk("cl_ready", wr_ready, 0);
      chk("cl_addr", ram_addr, 0);
      chk("cl_we", ram_we, 1);
      chk("cl_wdata", ram_wdata, 12'h00F);
      step();
      wr_valid = 1'b0;
      run_to_done(21000, 1'b0);
      clr_checks();
      chk("clr_busy_cycles", busy_cnt, FB_SZ);
      for (int i = 0; i < FB_SZ; i++) ref_mem[i] = 12'h00F;
      scan_line(0, 16);

      // Clear while the scan is running
      exp_clr = 12'h0F0; mon_clr = 1'b1; step(); mon_clr = 1'b0;
      video_on = 1'b1; curr_x = 10'd0; curr_y = 10'd0;
      clear_start = 1'b1; clear_color = 12'h0F0;
      step();
      clear_start = 1'b0; sx = 1; sy = 0;
      run_to_done(40000, 1'b1);
      video_on = 1'b0;
      clr_checks();
      chk("clr_ph0_writes", ph0_we, 0);

      // Reset in the middle of a clear
      video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      exp_clr = 12'h123; mon_clr = 1'b1; clear_start = 1'b1; clear_color = 12'h123;
      step();
      mon_clr = 1'b0; clear_start = 1'b0;
      begin
         int n = 0;
         while (n < 1000) begin
            @(negedge clk);
            if (ram_we && ram_addr == 15'd500) break;
            step();
            n++;
         end
         chk("r_reach500", (n < 1000) ? 1 : 0, 1);
      end
      reset = 1'b1;
      #1;
      chk("r_busy", busy, 0);
      chk("r_done", clear_done, 0);
      chk("r_ready", wr_ready, 0);
      chk("r_we", ram_we, 0);
      chk("r_rgb", rgb, 0);
      chk("r_hsync", hsync, 0);
      chk("r_vsync", vsync, 0);
      repeat (2) step();
      reset = 1'b0;
      chk("r_no_done", done_cnt, 0);
      step();
      mon_clr = 1'b1; exp_clr = 12'h456; clear_start = 1'b1; clear_color = 12'h456;
      @(negedge clk);
      chk("r2_busy0", busy, 0);
      step();
      clear_start = 1'b0; mon_clr = 1'b0;
      @(negedge clk);
      chk("r2_addr", ram_addr, 0);
      chk("r2_we", ram_we, 1);
      chk("r2_busy", busy, 1);
      step();
      run_to_done(21000, 1'b0);
      clr_checks();
      chk("r2_busy_cycles", busy_cnt, FB_SZ);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
